// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared state encoding and line helpers for mem_responder
package mem_resp_pkg;

   localparam int BEAT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      XFER = 2'b10
   } state_t;

   // Clears the word-offset bits inside a burst line (burst is a power of two).
   function automatic logic [31:0] line_mask(input int burst);
      return ~(32'(burst) - 32'd1);
   endfunction

endpackage

// File: rtl/word_ram.sv
// rtl/word_ram.sv - single-write, single-read word array with registered read data
module word_ram #(
   parameter int DATA_W    = 16,
   parameter int MEM_WORDS = 32768,
   localparam int AW       = $clog2(MEM_WORDS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [MEM_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Only the read register is reset; the storage keeps its contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - main-memory target: single-word writes, fixed-latency burst line reads
module mem_responder
   import mem_resp_pkg::*;
#(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16,
   parameter int LATENCY   = 4,
   parameter int BURST     = 8,
   parameter int MEM_WORDS = 65536 >> 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic              req_wr,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              wr_ack,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic [3:0]        rsp_beat,
   output logic              rsp_last,
   output logic              busy
);

   localparam int AW                     = $clog2(MEM_WORDS);
   localparam logic [31:0] MASK          = line_mask(BURST);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST - 1);
   localparam logic [BEAT_W-1:0] CNT_INIT  = (LATENCY > 1) ? BEAT_W'(LATENCY - 2) : '0;

   state_t            state, state_n;
   logic [BEAT_W-1:0] cnt, cnt_n, beat, beat_n, beat_inc;
   logic [AW-1:0]     base, base_n, req_idx, line_idx, raddr;
   logic              ram_we, ram_re;
   logic              unused_addr_lsb;

   assign unused_addr_lsb = req_addr[0];
   // Word index wraps modulo MEM_WORDS by keeping only the low AW bits.
   assign req_idx  = req_addr[AW:1];
   assign line_idx = req_idx & MASK[AW-1:0];
   assign beat_inc = beat + 4'd1;

   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign rsp_beat  = beat;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      beat_n  = beat;
      base_n  = base;
      ram_we  = 1'b0;
      ram_re  = 1'b0;
      raddr   = base;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (req_wr) begin
                  ram_we = 1'b1;
               end else begin
                  base_n = line_idx;
                  if (LATENCY > 1) begin
                     cnt_n   = CNT_INIT;
                     state_n = WAIT;
                  end else begin
                     state_n = XFER;
                     beat_n  = '0;
                     ram_re  = 1'b1;
                     raddr   = line_idx;
                  end
               end
            end
         end
         WAIT: begin
            if (cnt == '0) begin
               state_n = XFER;
               beat_n  = '0;
               ram_re  = 1'b1;
            end else begin
               cnt_n = cnt - 4'd1;
            end
         end
         XFER: begin
            if (beat == LAST_BEAT) begin
               state_n = IDLE;
               beat_n  = '0;
            end else begin
               // Fetch the next beat one cycle ahead so the data lands with its index.
               beat_n = beat_inc;
               ram_re = 1'b1;
               raddr  = base | AW'(beat_inc);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         beat      <= '0;
         base      <= '0;
         rsp_valid <= 1'b0;
         rsp_last  <= 1'b0;
         wr_ack    <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         beat      <= beat_n;
         base      <= base_n;
         rsp_valid <= (state_n == XFER);
         rsp_last  <= (state_n == XFER) && (beat_n == LAST_BEAT);
         wr_ack    <= ram_we;
      end
   end

   word_ram #(
      .DATA_W    (DATA_W),
      .MEM_WORDS (MEM_WORDS)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (ram_we),
      .waddr (req_idx),
      .wdata (req_wdata),
      .re    (ram_re),
      .raddr (raddr),
      .rdata (rsp_data)
   );

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized and directed bench for mem_responder with a cycle-level reference model
module tb_mem_responder;

   localparam int L  = 4;
   localparam int B  = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic        req_valid = 1'b0, req_wr = 1'b0;
   logic [15:0] req_addr = '0, req_wdata = '0;
   logic        req_ready, wr_ack, rsp_valid, rsp_last, busy;
   logic [15:0] rsp_data;
   logic [3:0]  rsp_beat;

   logic        s_valid = 1'b0, s_wr = 1'b0;
   logic [15:0] s_addr = '0, s_wdata = '0;
   logic        s_ready, s_ack, s_rvalid, s_last, s_busy;
   logic [15:0] s_rdata;
   logic [3:0]  s_beat;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   mem_responder #(.ADDR_W(16), .DATA_W(16), .LATENCY(L), .BURST(B), .MEM_WORDS(32768)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(req_ready), .wr_ack(wr_ack), .rsp_valid(rsp_valid),
      .rsp_data(rsp_data), .rsp_beat(rsp_beat), .rsp_last(rsp_last), .busy(busy)
   );

   mem_responder #(.ADDR_W(16), .DATA_W(16), .LATENCY(1), .BURST(1), .MEM_WORDS(32768)) dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(s_valid), .req_wr(s_wr), .req_addr(s_addr),
      .req_wdata(s_wdata), .req_ready(s_ready), .wr_ack(s_ack), .rsp_valid(s_rvalid),
      .rsp_data(s_rdata), .rsp_beat(s_beat), .rsp_last(s_last), .busy(s_busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: interval n is the time after the n-th rising edge.
   logic [15:0] m_mem [0:32767];
   logic [15:0] snap [B];
   int cyc = 0, ready_at = 0, ack_at = -1, start = -100;
   bit active = 1'b0;

   always @(posedge clk) begin
      int wi, base;
      cyc++;
      if (!rst_n) begin
         active   = 1'b0;
         ack_at   = -1;
         ready_at = 0;
      end else if (req_valid && (cyc - 1) >= ready_at) begin
         wi = int'(req_addr) / 2;
         if (req_wr) begin
            m_mem[wi] = req_wdata;
            ack_at    = cyc;
         end else begin
            base = (wi / B) * B;
            for (int i = 0; i < B; i++) snap[i] = m_mem[(base + i) % 32768];
            start    = cyc + L - 1;
            ready_at = cyc + L + B - 1;
            active   = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      bit ev;
      if (chk_en) begin
         ev = active && cyc >= start && cyc < start + B;
         chk("ready", req_ready, cyc >= ready_at);
         chk("busy", busy, cyc < ready_at);
         chk("wr_ack", wr_ack, cyc == ack_at);
         chk("rsp_valid", rsp_valid, ev);
         chk("rsp_last", rsp_last, ev && (cyc - start) == B - 1);
         if (ev) begin
            chk("rsp_beat", rsp_beat, cyc - start);
            chk("rsp_data", rsp_data, snap[cyc - start]);
         end
      end
   end

   task automatic send(input bit wr, input logic [15:0] a, input logic [15:0] d, output int waited);
      waited = 0;
      req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
      while (!req_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (!req_ready) begin
         failures++;
         $display("FAIL send_timeout ready=%0b required=1", req_ready);
      end
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic drain(output int low, output int nb);
      low = 0; nb = 0;
      for (int i = 0; i < 64 && !req_ready; i++) begin
         low++;
         if (rsp_valid) nb++;
         @(negedge clk);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int w, low, nb, n;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_ready", req_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_ack", wr_ack, 0);
      chk("rst_data", rsp_data, 16'h0000);
      chk_en = 1'b1;

      for (int i = 0; i < 64; i++) send(1'b1, 16'(i * 2), 16'($urandom), w);

      send(1'b1, 16'h0010, 16'hBEEF, w);
      chk("beef_ack", wr_ack, 1);
      @(negedge clk);
      chk("beef_ack_pulse", wr_ack, 0);
      send(1'b0, 16'h0010, 16'h0000, w);
      @(negedge clk); @(negedge clk);
      chk("beef_not_yet", rsp_valid, 0);
      @(negedge clk);
      chk("beef_valid", rsp_valid, 1);
      chk("beef_data", rsp_data, 16'hBEEF);
      chk("beef_beat", rsp_beat, 0);
      drain(low, nb);

      for (int i = 0; i < 8; i++) send(1'b1, 16'(32 + 2 * i), 16'(16'h1000 + i), w);
      send(1'b0, 16'h002B, 16'h0000, w);
      low = 0; nb = 0;
      for (int i = 0; i < 64 && !req_ready; i++) begin
         low++;
         if (rsp_valid) begin
            chk("line_data", rsp_data, 16'h1000 + nb);
            chk("line_beat", rsp_beat, nb);
            chk("line_last", rsp_last, nb == 7);
            nb++;
         end
         @(negedge clk);
      end
      chk("ready_low_cycles", low, 11);
      chk("line_beats", nb, 8);

      send(1'b0, 16'h002B, 16'h0000, w);
      send(1'b1, 16'h0020, 16'hCAFE, w);
      chk("held_wait_cycles", w, 11);
      chk("held_ack", wr_ack, 1);
      send(1'b0, 16'h0020, 16'h0000, w);
      repeat (3) @(negedge clk);
      chk("held_readback", rsp_data, 16'hCAFE);
      drain(low, nb);

      send(1'b0, 16'h002B, 16'h0000, w);
      n = 0;
      while (!(rsp_valid && rsp_beat == 4'd3) && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("reach_beat3", rsp_valid && rsp_beat == 4'd3, 1);
      chk_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", rsp_valid, 0);
      chk("arst_last", rsp_last, 0);
      chk("arst_busy", busy, 0);
      chk("arst_ready", req_ready, 1);
      chk("arst_data", rsp_data, 0);
      chk("arst_beat", rsp_beat, 0);
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk_en = 1'b1;
      nb = 0;
      for (int i = 0; i < 12; i++) begin
         if (rsp_valid) nb++;
         @(negedge clk);
      end
      chk("no_stray_beats", nb, 0);
      send(1'b0, 16'h002B, 16'h0000, w);
      drain(low, nb);
      chk("post_rst_low", low, 11);
      chk("post_rst_beats", nb, 8);

      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 2) == 0)
            send(1'b1, 16'($urandom_range(0, 63) * 2), 16'($urandom), w);
         else
            send(1'b0, 16'($urandom_range(0, 127)), 16'($urandom), w);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drain(low, nb);

      s_valid = 1'b1; s_wr = 1'b1; s_addr = 16'h0100; s_wdata = 16'h1234;
      chk("s_ready_idle", s_ready, 1);
      @(negedge clk);
      s_valid = 1'b0;
      chk("s_wr_ack", s_ack, 1);
      s_valid = 1'b1; s_wr = 1'b0;
      @(negedge clk);
      s_valid = 1'b0;
      chk("s_valid", s_rvalid, 1);
      chk("s_data", s_rdata, 16'h1234);
      chk("s_last", s_last, 1);
      chk("s_beat", s_beat, 0);
      chk("s_ready_busy", s_ready, 0);
      @(negedge clk);
      chk("s_valid_end", s_rvalid, 0);
      chk("s_ready_back", s_ready, 1);
      s_valid = 1'b1; s_wr = 1'b1; s_addr = 16'h0102; s_wdata = 16'h5678;
      @(negedge clk);
      s_wr = 1'b0;
      nb = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         chk("s_b2b_valid", s_rvalid, i % 2);
         if (s_rvalid) begin
            chk("s_b2b_data", s_rdata, 16'h5678);
            chk("s_b2b_last", s_last, 1);
            nb++;
         end
      end
      s_valid = 1'b0;
      chk("s_b2b_count", nb, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Multi-cycle main-memory responder: the target end of the CPU/cache-to-memory request interface.
- Accepts single-word writes and burst (cache-line) reads from one requester.
- Returns read beats after a fixed access latency.
- Replaces the single-cycle data/instruction memory models once the cache controller initiates line fills.

Parameters:
- ADDR_W, 16, byte-address width; word index = addr[ADDR_W-1:1].
- DATA_W, 16, word width.
- LATENCY, 4, cycles from read acceptance to first response beat; legal range 1..15.
- BURST, 8, words per read burst; power of two, 1..16.
- MEM_WORDS, 65536 >> 1 (32768), array depth in words.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- req_valid, input, 1, requester presents a request.
- req_wr, input, 1, 1 = single-word write, 0 = burst read.
- req_addr, input, ADDR_W, byte address; bit 0 ignored.
- req_wdata, input, DATA_W, write data.
- req_ready, output, 1, responder can accept a request this cycle.
- wr_ack, output, 1, one-cycle pulse confirming a write commit.
- rsp_valid, output, 1, read beat valid.
- rsp_data, output, DATA_W, read beat data.
- rsp_beat, output, 4, beat index within burst, 0..BURST-1.
- rsp_last, output, 1, final beat of burst.
- busy, output, 1, read burst in progress (state != IDLE).

Behaviour:
- Handshake:
  - A request transfers on a rising edge where req_valid & req_ready.
  - Requester holds req_* stable until the transfer.
  - req_valid while req_ready=0 is ignored, not queued.
- State IDLE (req_ready=1):
  - Write transfer: mem[word] <= req_wdata at that edge; wr_ack=1 for the following cycle only; stay IDLE.
  - Read transfer: base <= word index with low log2(BURST) bits cleared (line-aligned, low bits ignored).
  - Read transfer, LATENCY>1: cnt <= LATENCY-2, go to WAIT.
  - Read transfer, LATENCY=1: go to XFER, load beat 0.
- State WAIT (req_ready=0):
  - cnt decrements each cycle.
  - On the cnt==0 edge: go to XFER; rsp_data <= mem[base], beat <= 0.
- State XFER (req_ready=0):
  - rsp_valid=1; rsp_data and rsp_beat registered.
  - Each edge: beat+1, rsp_data <= mem[base+beat+1].
  - rsp_last=1 when beat==BURST-1; the next edge returns to IDLE with rsp_valid=0.
  - Beats are contiguous; the requester must always sink them (no back-pressure).
- Latency:
  - Read accepted at edge E0; beat 0 is valid in the cycle after edge E(LATENCY-1) relative to E0, i.e. LATENCY cycles after acceptance.
  - The last beat is valid LATENCY+BURST-1 cycles after acceptance.
  - Next request is accepted no earlier than the cycle after the last beat.
- Ordering:
  - Reads of an address written earlier return the written data, since writes commit before IDLE exits.
  - A write and a read cannot be accepted on the same edge.
- Addressing:
  - base+beat never crosses a line because base is aligned.
  - Word index beyond MEM_WORDS wraps modulo MEM_WORDS.
- Reset (async, rst_n=0), any state:
  - State=IDLE, cnt=0, beat=0.
  - req_ready=1 after release; rsp_valid=0, rsp_data=0, rsp_beat=0, rsp_last=0, wr_ack=0, busy=0.
  - A burst interrupted by reset is abandoned and no further beats are issued.
  - Array contents are not reset.
- Outputs are registered except req_ready and busy, which are decoded from state.

Decomposition:
- Package mem_resp_pkg:
  - state encoding IDLE=2'b00, WAIT=2'b01, XFER=2'b10.
  - Constant BEAT_W=4.
  - Function for the line-align mask.
- Sub-module word_ram:
  - DATA_W x MEM_WORDS.
  - One write port (we, waddr, wdata).
  - One read port (raddr), registered read inside.
  - No reset on storage.
- mem_responder holds the FSM, counters and response registers.

Test Plan (LATENCY=4, BURST=8):
- Reset release -> req_ready=1, busy=0, rsp_valid=0, wr_ack=0, rsp_data=16'h0000.
- Write addr 16'h0010 data 16'hBEEF -> wr_ack=1 exactly one cycle after the transfer edge. Then read addr 16'h0010 -> beat 0 (word 8) = 16'hBEEF, 4 cycles after acceptance.
- Preload words 16..23 with 16'h1000+i, read addr 16'h002B (odd, unaligned):
  - base=16, 8 contiguous beats 16'h1000..16'h1007.
  - rsp_beat 0..7; rsp_last only on beat 7.
  - req_ready=0 for 11 cycles.
- req_valid held high during WAIT/XFER with a write to 16'h0020 -> not accepted until IDLE; word 16 unchanged until then; accepted on the first IDLE edge.
- Assert rst_n=0 mid-XFER (beat 3) -> rsp_valid, rsp_last and busy fall immediately (async). After release, no stray beats; a new read completes normally.
- Parameter sweep LATENCY=1, BURST=1 -> beat 0 valid the cycle after acceptance with rsp_last=1; back-to-back reads accepted every 2 cycles.
